// File: rtl/day10_pkg.sv
// Shared definitions for the day-10 machine-line parser: ASCII codes, parser states
// and small character helpers.
package day10_pkg;

    localparam logic [7:0] CHAR_LBRACK = 8'h5B;
    localparam logic [7:0] CHAR_RBRACK = 8'h5D;
    localparam logic [7:0] CHAR_DOT    = 8'h2E;
    localparam logic [7:0] CHAR_HASH   = 8'h23;
    localparam logic [7:0] CHAR_LPAREN = 8'h28;
    localparam logic [7:0] CHAR_RPAREN = 8'h29;
    localparam logic [7:0] CHAR_LBRACE = 8'h7B;
    localparam logic [7:0] CHAR_RBRACE = 8'h7D;
    localparam logic [7:0] CHAR_COMMA  = 8'h2C;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_NL     = 8'h0A;
    localparam logic [7:0] CHAR_CR     = 8'h0D;

    typedef enum logic [3:0] {
        StIdle,
        StLights,
        StButtons,
        StBtnIdx,
        StJolt,
        StEnd,
        StSkip,
        StEmit,
        StWaitHi,
        StWaitLo
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic accepts_bytes(input parser_state_t s);
        return s inside {StIdle, StLights, StButtons, StBtnIdx, StJolt, StEnd, StSkip};
    endfunction

endpackage

// File: rtl/day10_line_parser_accum.sv
// Decimal digit accumulator: value = value*10 + digit, saturating at all-ones.
module ascii_uint_accum #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [3:0]   digit,
    output logic [W-1:0] value
);

    localparam int unsigned PW = W + 4;

    logic [W-1:0]  value_q;
    logic [PW-1:0] prod;
    logic [W-1:0]  sat;

    // value*10+9 < 16*2^W, so PW bits never overflow before saturation.
    always_comb begin
        prod = {4'b0000, value_q} * PW'(10) + {{W{1'b0}}, digit};
        sat  = (|prod[PW-1:W]) ? {W{1'b1}} : prod[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (en) begin
            value_q <= sat;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/day10_line_parser.sv
// Parses day-10 machine lines from an ASCII byte stream into light/button fields and
// hands each good line to the consumer with a start pulse and busy handshake.
module day10_line_parser
    import day10_pkg::*;
#(
    parameter int unsigned MAX_NUM_LIGHTS    = 10,
    parameter int unsigned MAX_NUM_BUTTONS   = 13,
    parameter int unsigned MAX_NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 1),
    parameter int unsigned MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int unsigned AXI_DATA_WIDTH    = 8
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [AXI_DATA_WIDTH-1:0]                        char_stream_tdata,
    input  logic                                             char_stream_tvalid,
    output logic                                             char_stream_tready,
    input  logic                                             char_stream_tlast,
    output logic [MAX_NUM_LIGHTS_W-1:0]                      num_lights,
    output logic [MAX_NUM_LIGHTS-1:0]                        target_lights_arrangement,
    output logic [MAX_NUM_BUTTONS_W-1:0]                     num_buttons,
    output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]   buttons,
    output logic                                             start,
    input  logic                                             day10_input_busy,
    output logic                                             parse_error,
    output logic [15:0]                                      lines_emitted
);

    localparam int unsigned NLW = MAX_NUM_LIGHTS_W;
    localparam int unsigned NBW = MAX_NUM_BUTTONS_W;
    localparam logic [NLW-1:0] MaxLights  = NLW'(MAX_NUM_LIGHTS);
    localparam logic [NBW-1:0] MaxButtons = NBW'(MAX_NUM_BUTTONS);

    parser_state_t state_q, state_d;
    logic          tready_q, start_q, parse_error_q, have_digit_q;
    logic [15:0]   lines_q;
    logic [NLW-1:0] num_lights_q;
    logic [MAX_NUM_LIGHTS-1:0] target_q;
    logic [NBW-1:0] num_buttons_q;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons_q;

    logic [7:0]     ch;
    logic           fire, eol, tlast;
    logic [NLW-1:0] idx_value;
    logic set_err, line_clear, light_wr, acc_clr, acc_en, btn_set, btn_close;
    logic emit_req, do_start;

    assign ch    = char_stream_tdata[7:0];
    assign tlast = char_stream_tlast;
    assign fire  = char_stream_tvalid && tready_q;
    assign eol   = (ch == CHAR_NL) || tlast;

    ascii_uint_accum #(
        .W(NLW)
    ) u_idx_accum (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .en   (acc_en),
        .digit(ch[3:0]),
        .value(idx_value)
    );

    always_comb begin
        state_d    = state_q;
        set_err    = 1'b0;
        line_clear = 1'b0;
        light_wr   = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        btn_set    = 1'b0;
        btn_close  = 1'b0;
        emit_req   = 1'b0;
        do_start   = 1'b0;
        case (state_q)
            StIdle: if (fire) begin
                if (ch == CHAR_LBRACK) begin
                    if (tlast) set_err = 1'b1;
                    else begin
                        line_clear = 1'b1;
                        state_d    = StLights;
                    end
                end else if (!(ch == CHAR_NL || ch == CHAR_CR || ch == CHAR_SPACE)) begin
                    set_err = 1'b1;
                end
            end
            StLights: if (fire) begin
                if (tlast) set_err = 1'b1;
                else if (ch == CHAR_DOT || ch == CHAR_HASH) begin
                    if (num_lights_q == MaxLights) set_err = 1'b1;
                    else light_wr = 1'b1;
                end else if (ch == CHAR_RBRACK) begin
                    if (num_lights_q == '0) set_err = 1'b1;
                    else state_d = StButtons;
                end else set_err = 1'b1;
            end
            StButtons: if (fire) begin
                if (tlast) set_err = 1'b1;
                else if (ch == CHAR_LPAREN) begin
                    if (num_buttons_q == MaxButtons) set_err = 1'b1;
                    else begin
                        acc_clr = 1'b1;
                        state_d = StBtnIdx;
                    end
                end else if (ch == CHAR_LBRACE) state_d = StJolt;
                else if (ch != CHAR_SPACE) set_err = 1'b1;
            end
            StBtnIdx: if (fire) begin
                if (tlast) set_err = 1'b1;
                else if (is_digit(ch)) acc_en = 1'b1;
                else if (ch == CHAR_COMMA || ch == CHAR_RPAREN) begin
                    // have_digit catches "()", "(," and a trailing ",)"
                    if (!have_digit_q || idx_value >= num_lights_q) set_err = 1'b1;
                    else begin
                        btn_set = 1'b1;
                        if (ch == CHAR_COMMA) acc_clr = 1'b1;
                        else begin
                            btn_close = 1'b1;
                            state_d   = StButtons;
                        end
                    end
                end else set_err = 1'b1;
            end
            StJolt: if (fire) begin
                if (is_digit(ch) || ch == CHAR_COMMA) begin
                    if (tlast) set_err = 1'b1;
                end else if (ch == CHAR_RBRACE) begin
                    if (tlast) emit_req = 1'b1;
                    else state_d = StEnd;
                end else set_err = 1'b1;
            end
            StEnd: if (fire) begin
                if (eol) emit_req = 1'b1;
                else if (!(ch == CHAR_CR || ch == CHAR_SPACE)) set_err = 1'b1;
            end
            StSkip: if (fire && eol) state_d = StIdle;
            StEmit:   emit_req = 1'b1;
            StWaitHi: if (day10_input_busy) state_d = StWaitLo;
            StWaitLo: if (!day10_input_busy) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (emit_req) begin
            if (!day10_input_busy) begin
                do_start = 1'b1;
                state_d  = StWaitHi;
            end else begin
                state_d = StEmit;
            end
        end
        if (set_err) state_d = eol ? StIdle : StSkip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tready_q      <= 1'b0;
            start_q       <= 1'b0;
            parse_error_q <= 1'b0;
            have_digit_q  <= 1'b0;
            lines_q       <= '0;
            num_lights_q  <= '0;
            target_q      <= '0;
            num_buttons_q <= '0;
            buttons_q     <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= accepts_bytes(state_d);
            start_q  <= do_start;
            if (do_start) lines_q <= lines_q + 16'd1;
            if (set_err) parse_error_q <= 1'b1;
            if (acc_clr) have_digit_q <= 1'b0;
            else if (acc_en) have_digit_q <= 1'b1;
            if (line_clear) begin
                num_lights_q  <= '0;
                target_q      <= '0;
                num_buttons_q <= '0;
                buttons_q     <= '0;
            end
            if (light_wr) begin
                target_q[num_lights_q] <= (ch == CHAR_HASH);
                num_lights_q           <= num_lights_q + NLW'(1);
            end
            if (btn_set) buttons_q[num_buttons_q][idx_value] <= 1'b1;
            if (btn_close) num_buttons_q <= num_buttons_q + NBW'(1);
        end
    end

    assign char_stream_tready        = tready_q;
    assign start                     = start_q;
    assign parse_error               = parse_error_q;
    assign lines_emitted             = lines_q;
    assign num_lights                = num_lights_q;
    assign target_lights_arrangement = target_q;
    assign num_buttons               = num_buttons_q;
    assign buttons                   = buttons_q;

endmodule

// File: tb/tb_day10_line_parser.sv
// Directed and randomized bench for day10_line_parser against a string-level line model.
module tb_day10_line_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [3:0]  num_lights;
    logic [9:0]  target;
    logic [3:0]  num_buttons;
    logic [12:0][9:0] buttons;
    logic        start;
    logic        busy = 1'b0;
    logic        parse_error;
    logic [15:0] lines_emitted;

    typedef struct {
        int           nl;
        logic [9:0]   tgt;
        int           nb;
        logic [129:0] btn;
    } rec_t;

    rec_t got_q[$];
    bit   auto_busy = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_lines = 0;

    always #5 clk = ~clk;

    day10_line_parser dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .char_stream_tdata        (tdata),
        .char_stream_tvalid       (tvalid),
        .char_stream_tready       (tready),
        .char_stream_tlast        (tlast),
        .num_lights               (num_lights),
        .target_lights_arrangement(target),
        .num_buttons              (num_buttons),
        .buttons                  (buttons),
        .start                    (start),
        .day10_input_busy         (busy),
        .parse_error              (parse_error),
        .lines_emitted            (lines_emitted)
    );

    // Capture the payload on every start pulse.
    initial forever begin
        @(negedge clk);
        if (start === 1'b1) begin
            rec_t r;
            r.nl  = int'(num_lights);
            r.tgt = target;
            r.nb  = int'(num_buttons);
            r.btn = buttons;
            got_q.push_back(r);
        end
    end

    // Auto consumer: take the machine one cycle after start, hold it two cycles.
    initial forever begin
        @(negedge clk);
        if (auto_busy && start === 1'b1) begin
            @(negedge clk);
            busy = 1'b1;
            repeat (2) @(negedge clk);
            busy = 1'b0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit isd(input byte c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Reference grammar over the whole line string.
    function automatic void model_line(input string s, input bit use_tlast,
                                       output bit ok, output rec_t e);
        int p;
        int len;
        int v;
        e.nl = 0; e.tgt = '0; e.nb = 0; e.btn = '0;
        ok  = 1'b0;
        len = s.len();
        if (len == 0 || s[0] != "[") return;
        p = 1;
        while (p < len && (s[p] == "." || s[p] == "#")) begin
            if (e.nl >= 10) return;
            e.tgt[e.nl] = (s[p] == "#");
            e.nl++;
            p++;
        end
        if (e.nl == 0 || p >= len || s[p] != "]") return;
        p++;
        while (1) begin
            while (p < len && s[p] == " ") p++;
            if (p >= len) return;
            if (s[p] == "{") break;
            if (s[p] != "(" || e.nb == 13) return;
            p++;
            while (1) begin
                if (p >= len || !isd(s[p])) return;
                v = 0;
                while (p < len && isd(s[p])) begin
                    v = v * 10 + int'(s[p]) - 48;
                    if (v > 1000) v = 1000;
                    p++;
                end
                if (v >= e.nl) return;
                e.btn[e.nb*10 + v] = 1'b1;
                if (p < len && s[p] == ",") p++;
                else if (p < len && s[p] == ")") begin
                    p++;
                    break;
                end else return;
            end
            e.nb++;
        end
        p++;
        while (p < len && (isd(s[p]) || s[p] == ",")) p++;
        if (p >= len || s[p] != "}") return;
        p++;
        while (p < len && (s[p] == " " || s[p] == "\r")) p++;
        if (p == len) ok = use_tlast;
        else ok = (s[p] == "\n") && (p == len - 1);
    endfunction

    task automatic send_byte(input byte b, input logic last, input int max_gap);
        int n = 0;
        @(negedge clk);
        tdata  = b;
        tvalid = 1'b1;
        tlast  = last;
        while (tready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 500) else begin
            failures++;
            $error("FAIL tready_timeout observed=0 expected=1 byte=%0h", b);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    endtask

    task automatic send_line(input string s, input bit use_tlast, input int max_gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], use_tlast && (i == s.len() - 1), max_gap);
    endtask

    task automatic check_rec(input string tag, input rec_t g, input rec_t e);
        check({tag, ":nl"}, g.nl, e.nl);
        check({tag, ":tgt"}, g.tgt, e.tgt);
        check({tag, ":nb"}, g.nb, e.nb);
        check({tag, ":btn"}, g.btn, e.btn);
    endtask

    task automatic run_line(input string tag, input string s, input bit use_tlast,
                            input int max_gap, input bit check_lat, output rec_t got);
        bit   ok;
        rec_t e;
        model_line(s, use_tlast, ok, e);
        got_q.delete();
        send_line(s, use_tlast, max_gap);
        if (check_lat) check({tag, ":latency"}, start, 1'b1);
        repeat (10) @(negedge clk);
        if (ok) exp_lines++;
        check({tag, ":starts"}, got_q.size(), ok ? 1 : 0);
        check({tag, ":lines"}, lines_emitted, exp_lines[15:0]);
        got = e;
        if (got_q.size() > 0) begin
            got = got_q[0];
            if (ok) check_rec(tag, got_q[0], e);
        end
        if (!ok) check({tag, ":perr"}, parse_error, 1'b1);
    endtask

    function automatic string gen_line(input int mode);
        int    n  = int'($urandom_range(10, 1));
        int    ng = int'($urandom_range(6, 1));
        int    k;
        int    v;
        string s  = "[";
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1, 0) == 1) s = {s, "#"};
            else s = {s, "."};
        end
        s = {s, "]"};
        for (int g = 0; g < ng; g++) begin
            s = {s, " ("};
            k = int'($urandom_range(3, 1));
            for (int j = 0; j < k; j++) begin
                if (j > 0) s = {s, ","};
                v = int'($urandom_range(n - 1, 0));
                if (mode == 1 && g == ng - 1 && j == 0) v = n;
                s = {s, $sformatf("%0d", v)};
            end
            s = {s, ")"};
        end
        if (mode != 2) begin
            s = {s, " {"};
            k = int'($urandom_range(4, 1));
            for (int j = 0; j < k; j++) begin
                if (j > 0) s = {s, ","};
                s = {s, $sformatf("%0d", $urandom_range(300, 0))};
            end
            s = {s, "}"};
        end
        return s;
    endfunction

    initial begin
        rec_t  g;
        rec_t  e1;
        rec_t  snap;
        bit    ok;
        string s;
        string l1;
        string l2;
        bit    tl;
        int    mode;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst:tready", tready, 1'b0);
        check("rst:start", start, 1'b0);
        check("rst:perr", parse_error, 1'b0);
        check("rst:lines", lines_emitted, 16'd0);
        check("rst:fields", {num_lights, target, num_buttons, buttons}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle:tready", tready, 1'b1);

        // 1: reference line, back-to-back bytes
        l1 = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n";
        run_line("t1", l1, 1'b0, 0, 1'b1, g);
        check("t1:tgt_const", g.tgt, 10'b0000000110);
        check("t1:nb_const", g.nb, 6);
        check("t1:b1_const", g.btn[19:10], 10'b0000001010);
        check("t1:b5_const", g.btn[59:50], 10'b0000000011);
        check("t1:perr0", parse_error, 1'b0);

        // 3: index out of range, then recovery
        run_line("t3a", "[#.] (2) {1}\n", 1'b0, 0, 1'b0, g);
        run_line("t3b", "[#] (0) {1}\n", 1'b0, 0, 1'b0, g);
        check("t3b:tgt_const", g.tgt, 10'b1);
        check("t3b:b0_const", g.btn[9:0], 10'b1);

        // 4: multi-digit index boundary
        run_line("t4a", "[##########] (10) (9) {0}\n", 1'b0, 1, 1'b0, g);
        run_line("t4b", "[##########] (9) {0}\n", 1'b0, 1, 1'b0, g);
        check("t4b:b0_const", g.btn[9:0], 10'b1000000000);
        run_line("t4c", "[.#] () {1}\n", 1'b0, 0, 1'b0, g);
        run_line("t4d", "[.#] (1) \n", 1'b0, 0, 1'b0, g);

        // 5: tlast on '}' with and without gaps
        run_line("t5a", "[.#.#] (0,3) (1) {2,9}", 1'b1, 0, 1'b1, g);
        run_line("t5b", "[.#.#] (0,3) (1) {2,9}", 1'b1, 3, 1'b0, g);
        run_line("t5c", "[.#.#] (0,3)", 1'b1, 2, 1'b0, g);

        // 2: consumer busy before line ends
        auto_busy = 1'b0;
        @(negedge clk);
        busy = 1'b1;
        model_line(l1, 1'b0, ok, e1);
        got_q.delete();
        send_line(l1, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("t2:nostart", got_q.size(), 0);
        check("t2:tready_emit", tready, 1'b0);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        check("t2:start_once", got_q.size(), 1);
        exp_lines++;
        if (got_q.size() > 0) check_rec("t2", got_q[0], e1);
        snap.nl = int'(num_lights); snap.tgt = target; snap.nb = int'(num_buttons);
        snap.btn = buttons;
        busy = 1'b1;
        l2 = "[#..#] (0) (3,1) {4}\n";
        fork
            send_line(l2, 1'b0, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("t2:stall_tready", tready, 1'b0);
                    check("t2:frozen", {num_lights, target, num_buttons, buttons},
                          {snap.nl[3:0], snap.tgt, snap.nb[3:0], snap.btn});
                end
                busy      = 1'b0;
                auto_busy = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        model_line(l2, 1'b0, ok, e1);
        if (ok) exp_lines++;
        check("t2:second", got_q.size(), ok ? 2 : 1);
        check("t2:lines", lines_emitted, exp_lines[15:0]);
        if (got_q.size() > 1) check_rec("t2b", got_q[1], e1);

        // Randomized lines
        for (int i = 0; i < 25; i++) begin
            mode = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            s    = gen_line(mode);
            tl   = ($urandom_range(1, 0) == 1);
            if (!tl) s = {s, "\n"};
            run_line($sformatf("rnd%0d", i), s, tl, 3, 1'b0, g);
        end

        // 6: asynchronous reset while inside a button group
        send_line("[.#] (1", 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6:tready", tready, 1'b0);
        check("t6:start", start, 1'b0);
        check("t6:perr", parse_error, 1'b0);
        check("t6:lines", lines_emitted, 16'd0);
        check("t6:fields", {num_lights, target, num_buttons, buttons}, '0);
        got_q.delete();
        exp_lines = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_line("t6b", "[.#] (1) (0,1) {7}\n", 1'b0, 1, 1'b0, g);
        check("t6b:perr0", parse_error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
